// File: rtl/add_seq_arbiter.sv
// rtl/add_seq_arbiter.sv - two-requester round-robin arbiter feeding a 4-bit-slice sequential adder
// Optional macro LOW_BYTE_ONLY_EN: operand bits [15:8] forced to zero at capture.
module add_seq_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic        req1,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [16:0] S
);

  typedef enum logic [1:0] {IDLE, GRANT, ADD, DONE} state_t;

  state_t      state;
  logic        win;
  logic        last_served;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] acc;
  logic        carry;
  logic [1:0]  k;

  logic        pick;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  slice;

  // Round robin: on a tie the requester not served last wins.
  always_comb begin
    pick = (req0 && req1) ? ~last_served : req1;
  end

  always_comb begin
    cap_a = win ? A1 : A0;
    cap_b = win ? B1 : B0;
`ifdef LOW_BYTE_ONLY_EN
    cap_a = {8'h00, cap_a[7:0]};
    cap_b = {8'h00, cap_b[7:0]};
`endif
  end

  // The single shared 4-bit ripple slice, stepped across the operands by k.
  always_comb begin
    a_nib = a_q[{k, 2'b00} +: 4];
    b_nib = b_q[{k, 2'b00} +: 4];
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      win         <= 1'b0;
      last_served <= 1'b1;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      acc         <= 16'h0000;
      carry       <= 1'b0;
      k           <= 2'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      S           <= 17'h00000;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win   <= pick;
            gnt0  <= ~pick;
            gnt1  <= pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          a_q   <= cap_a;
          b_q   <= cap_b;
          k     <= 2'd0;
          carry <= 1'b0;
          state <= ADD;
        end
        ADD: begin
          acc[{k, 2'b00} +: 4] <= slice[3:0];
          carry <= slice[4];
          k     <= k + 2'd1;
          if (k == 2'd3) begin
            // Final nibble bypasses acc so S is ready in the DONE cycle.
            S           <= {slice, acc[11:0]};
            done        <= 1'b1;
            done_id     <= win;
            last_served <= win;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/add_seq_arbiter.md
ADD_SEQ_ARBITER -- requirements
Module: add_seq_arbiter

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits, the result at 17 bits and the slice at 4 bits.
REQ-002 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 wants an addition; held high with stable operands until gnt0.
REQ-005 A0, B0  input  16 each  requester 0 operands.
REQ-006 req1  input  1  requester 1 request, same rules as req0.
REQ-007 A1, B1  input  16 each  requester 1 operands.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands are captured at the end of that cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; S valid in that cycle.
REQ-011 done_id  output  1  requester served by the current or most recent done.
REQ-012 S  output  17  sum, with S[16] = final carry-out.

Function
REQ-013 The FSM SHALL have the states IDLE, GRANT, ADD and DONE, all outputs being Moore outputs.
REQ-014 IDLE: if any req is high, latch the winner and go to GRANT; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin on the last_served register: if both requests are high, grant the requester not last served; if only one is high, grant it.
REQ-016 GRANT: assert the winner's gnt for exactly one cycle, capture its A/B into internal registers, clear nibble count k and carry, then go to ADD.
REQ-017 ADD SHALL last exactly 4 cycles, with k = 0..3.
REQ-018 Each ADD cycle SHALL compute {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry, using one shared 4-bit ripple slice.
REQ-019 In each ADD cycle, s SHALL be stored into acc[4k+3:4k] and c registered as carry.
REQ-020 After k = 3, the FSM SHALL go to DONE.
REQ-021 DONE (1 cycle): assert done, drive S = {carry, acc}, set done_id and last_served to the winner, then go to IDLE.
REQ-022 Latency: a request first sampled in IDLE at cycle t SHALL give its gnt at t+1 and its done at t+6.
REQ-023 Throughput: at most one operation per 7 cycles.
REQ-024 S and done_id SHALL hold their values from done until the next done.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; the non-granted requester's pending req SHALL be served next.
REQ-026 A requester that drops req after the IDLE decision SHALL still be granted; its operands are whatever is present in the GRANT cycle.
REQ-027 Overflow SHALL NOT be possible: 0xFFFF + 0xFFFF = 0x1FFFE.

Reset
REQ-028 Reset SHALL set the FSM to IDLE, gnt0/gnt1/busy/done to 0, done_id to 0, S to 0, acc to 0, carry to 0, k to 0 and last_served to 1, so that req0 wins the first tie.
REQ-029 Reset mid-operation (GRANT/ADD/DONE) SHALL abort the operation with no done pulse, leaving the reset values of REQ-028 on the next cycle.
REQ-030 Reset SHALL take priority over every other transition in the same cycle.

Configuration
REQ-031 Macro LOW_BYTE_ONLY_EN, when defined: operand bits [15:8] SHALL be forced to 0 at capture (8-bit board switch inputs), so only the low byte of A/B is added.
REQ-032 LOW_BYTE_ONLY_EN: the ADD sequence stays 4 cycles regardless.
REQ-033 Macro LOW_BYTE_ONLY_EN, when undefined: full 16-bit operands SHALL be used.

Verification
REQ-034 Single request: req0, A0=0x00FF, B0=0x0001 at IDLE cycle t -> gnt0 at t+1, done at t+6, S=0x00100, done_id=0.
REQ-035 Full carry chain: A0=0xFFFF, B0=0x0001 -> S=0x10000. Maximum operands: A0=B0=0xFFFF -> S=0x1FFFE.
REQ-036 Tie after reset: req0 and req1 high together -> gnt0 first, done_id=0. Then with req1 still held -> gnt1 one cycle after returning to IDLE, done_id=1. Next tie -> gnt0.
REQ-037 Reset at ADD k=2 -> no done, S=0, busy=0 the next cycle. A subsequent A1=0x0003, B1=0x0004 -> S=0x00007.
REQ-038 A0=0x1234, B0=0x0101 -> with LOW_BYTE_ONLY_EN S=0x00035; without it S=0x01335.
